i2c_eeprom_master: RTL and testbench
====================================

I2C_EEPROM_MASTER -- requirements
Module: i2c_eeprom_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCL_FREQ, default 100_000, SCL frequency in Hz.
REQ-003 SHALL have parameter DEV_ADDR, default 3'b000, device pins A2..A0 placed in the control byte.
REQ-004 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle transaction request.
REQ-007 SHALL have port rw  input  1  0 = byte write, 1 = random read.
REQ-008 SHALL have port addr  input  13  EEPROM byte address.
REQ-009 SHALL have port wdata  input  8  write data.
REQ-010 SHALL have port rdata  output  8  read data.
REQ-011 SHALL have port busy  output  1  transaction in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port ack_err  output  1  a NACK was sampled in an ACK slot.
REQ-014 SHALL have port scl  output  1  I2C clock, push-pull, single master, no clock stretching.
REQ-015 SHALL have port sda  inout  1  I2C data, open-drain: drives 0 or z, never 1.

Function
REQ-016 SHALL derive Q = CLK_FREQ/(4*SCL_FREQ) clk cycles per quarter-bit (Q >= 2); each SCL bit = quarters q0..q3.
REQ-017 SHALL hold scl low in q0 and q3 and high in q1 and q2.
REQ-018 SHALL change sda only at q0 start, and SHALL sample sda at q2 start.
REQ-019 SHALL keep scl=1 and sda released when idle.
REQ-020 START/repeated START: sda falls while scl high. STOP: sda rises while scl high.
REQ-021 SHALL accept start only when busy=0, latching rw/addr/wdata; start while busy SHALL be ignored.
REQ-022 SHALL clear ack_err on acceptance and assert busy from the next cycle.
REQ-023 Write sequence: START, ctrl 8'b1010_{DEV_ADDR}_0, ACK, {3'b000,addr[12:8]}, ACK, addr[7:0], ACK, wdata, ACK, STOP.
REQ-024 Read sequence: START, ctrl_W, ACK, addr_h, ACK, addr_l, ACK, Sr, ctrl 8'b1010_{DEV_ADDR}_1, ACK, 8 data bits sampled, master NACK (sda released), STOP.
REQ-025 SHALL send and receive all bytes MSB first, releasing sda for every slave ACK slot and every read data bit.
REQ-026 FSM states: IDLE, START, SEND_BYTE, GET_ACK, RESTART, RECV_BYTE, SEND_NACK, STOP; a 3-bit counter tracks bit index.
REQ-027 SHALL update rdata on a read before done, and SHALL hold it until the next read completes; writes leave rdata unchanged.
REQ-028 At STOP completion: busy falls and done pulses high for exactly one clk in the same cycle.

Reset
REQ-029 rst SHALL immediately force IDLE: scl=1, sda released, busy=0, done=0, ack_err=0, rdata=8'h00, counters 0.
REQ-030 Reset mid-transaction SHALL abandon the frame without generating STOP; the next start SHALL run a normal frame.

Configuration
REQ-031 Macro ACK_CHECK_EN defined: a NACK (sda=1) sampled in any slave ACK slot SHALL set ack_err and jump to STOP; done pulses as normal.
REQ-032 Macro ACK_CHECK_EN undefined: ACK slots are clocked but not evaluated; the full sequence always runs and ack_err is tied 0.

Verification
REQ-033 Write addr=13'h0123, wdata=8'hA5 with an EEPROM slave model -> bus bytes A0,01,23,A5 all ACKed, STOP, done pulse, ack_err=0, slave memory[0x123]=A5.
REQ-034 Read addr=13'h0123 -> bytes A0,01,23, Sr, A1, master NACK, STOP; rdata=8'hA5 when done pulses.
REQ-035 Write 8'h3C to 13'h1FFF, then read it -> addr_h byte 8'h1F, rdata=8'h3C; CLK_FREQ 50 MHz / SCL_FREQ 100 kHz gives a 500-clk SCL period.
REQ-036 No slave present (sda pulled up) -> with ACK_CHECK_EN: STOP after ctrl byte, ack_err=1, done pulse; without: all 4 bytes clocked, ack_err=0.
REQ-037 start pulse while busy -> ignored, frame unchanged.
REQ-038 rst mid addr_h byte -> scl=1, sda=z, busy=0 at once; next write completes correctly.

Source files
------------

// File: rtl/i2c_eeprom_master.sv
// Single-master I2C controller for 24xx-style EEPROMs: byte write and random read, 13-bit address.
// Define ACK_CHECK_EN to evaluate slave ACK slots and abort to STOP on a NACK.
module i2c_eeprom_master #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ = 100_000,
  parameter logic [2:0]  DEV_ADDR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [12:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  inout  logic        sda
);

  localparam int unsigned Q  = CLK_FREQ / (4 * SCL_FREQ);
  localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RESTART, RECV_BYTE, SEND_NACK, STOP
  } state_t;

  state_t      state, state_n;
  logic [1:0]  phase, phase_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  byte_idx, byte_idx_n;
  logic [7:0]  tx_sh, tx_n;
  logic [7:0]  rx_sh, rx_n;
  logic        rw_q, rw_n;
  logic [12:0] addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [7:0]  rdata_n;
  logic        done_n, busy_n;
  logic        scl_n, sda_low, sda_low_n;
  logic        q_end, bit_end;
  logic        abort;
  logic        ack_err_n;
  logic        nack, nack_n;

  assign sda = sda_low ? 1'b0 : 1'bz;

`ifdef ACK_CHECK_EN
  assign abort = nack;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    qcnt_n     = qcnt;
    bit_cnt_n  = bit_cnt;
    byte_idx_n = byte_idx;
    tx_n       = tx_sh;
    rx_n       = rx_sh;
    rw_n       = rw_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    rdata_n    = rdata;
    done_n     = 1'b0;
    ack_err_n  = ack_err;
    nack_n     = nack;
    q_end      = (qcnt == QW'(Q - 1));
    bit_end    = q_end && (phase == 2'd3);

    if (state == IDLE) begin
      if (start) begin
        state_n   = START;
        qcnt_n    = '0;
        phase_n   = '0;
        rw_n      = rw;
        addr_n    = addr;
        wdata_n   = wdata;
        ack_err_n = 1'b0;
      end
    end else begin
      if (q_end) begin
        qcnt_n  = '0;
        phase_n = phase + 2'd1;
      end else begin
        qcnt_n = qcnt + QW'(1);
      end

      // sda is sampled at the start of q2, in the middle of the scl high time
      if (q_end && phase == 2'd1) begin
        if (state == RECV_BYTE) rx_n = {rx_sh[6:0], sda};
        if (state == GET_ACK)   nack_n = sda;
      end

      if (bit_end) begin
        case (state)
          START: begin
            state_n    = SEND_BYTE;
            tx_n       = {4'b1010, DEV_ADDR, 1'b0};
            bit_cnt_n  = 3'd7;
            byte_idx_n = 3'd0;
          end
          SEND_BYTE: begin
            if (bit_cnt == 3'd0) begin
              state_n = GET_ACK;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
              tx_n      = {tx_sh[6:0], 1'b0};
            end
          end
          GET_ACK: begin
            bit_cnt_n = 3'd7;
            if (abort) begin
              ack_err_n = 1'b1;
              state_n   = STOP;
            end else begin
              case (byte_idx)
                3'd0: begin
                  state_n    = SEND_BYTE;
                  tx_n       = {3'b000, addr_q[12:8]};
                  byte_idx_n = 3'd1;
                end
                3'd1: begin
                  state_n    = SEND_BYTE;
                  tx_n       = addr_q[7:0];
                  byte_idx_n = 3'd2;
                end
                3'd2: begin
                  if (rw_q) begin
                    state_n = RESTART;
                  end else begin
                    state_n    = SEND_BYTE;
                    tx_n       = wdata_q;
                    byte_idx_n = 3'd3;
                  end
                end
                3'd4:    state_n = RECV_BYTE;
                default: state_n = STOP;
              endcase
            end
          end
          RESTART: begin
            state_n    = SEND_BYTE;
            tx_n       = {4'b1010, DEV_ADDR, 1'b1};
            bit_cnt_n  = 3'd7;
            byte_idx_n = 3'd4;
          end
          RECV_BYTE: begin
            if (bit_cnt == 3'd0) state_n = SEND_NACK;
            else                 bit_cnt_n = bit_cnt - 3'd1;
          end
          SEND_NACK: begin
            rdata_n = rx_sh;
            state_n = STOP;
          end
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end

    busy_n = (state_n != IDLE);

    // Bus pins are registered from the next-state view so they never glitch
    scl_n     = 1'b1;
    sda_low_n = 1'b0;
    case (state_n)
      IDLE: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
      START: begin
        scl_n     = (phase_n != 2'd3);
        sda_low_n = phase_n[1];
      end
      RESTART: begin
        scl_n     = (phase_n == 2'd1) || (phase_n == 2'd2);
        sda_low_n = phase_n[1];
      end
      STOP: begin
        scl_n     = (phase_n != 2'd0);
        sda_low_n = !phase_n[1];
      end
      SEND_BYTE: begin
        scl_n     = (phase_n == 2'd1) || (phase_n == 2'd2);
        sda_low_n = !tx_n[7];
      end
      default: begin
        scl_n     = (phase_n == 2'd1) || (phase_n == 2'd2);
        sda_low_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      qcnt     <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      scl      <= 1'b1;
      sda_low  <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      qcnt     <= qcnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_idx <= byte_idx_n;
      tx_sh    <= tx_n;
      rx_sh    <= rx_n;
      rw_q     <= rw_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
      done     <= done_n;
      scl      <= scl_n;
      sda_low  <= sda_low_n;
    end
  end

`ifdef ACK_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_err <= 1'b0;
      nack    <= 1'b0;
    end else begin
      ack_err <= ack_err_n;
      nack    <= nack_n;
    end
  end
`else
  assign ack_err = 1'b0;
  assign nack    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Bench for i2c_eeprom_master: EEPROM slave model on the bus, scoreboard of expected bus
// tokens and per-transaction results.
`timescale 1ns/1ps
module tb_i2c_eeprom_master;

  localparam int unsigned CLK_FREQ = 2_000_000;
  localparam int unsigned SCL_FREQ = 100_000;
  localparam int unsigned Q        = CLK_FREQ / (4 * SCL_FREQ);
  localparam logic [2:0]  DEV      = 3'b000;

  localparam logic [9:0] TOK_S     = 10'h100;
  localparam logic [9:0] TOK_P     = 10'h101;
  localparam logic [9:0] TOK_MNACK = 10'h102;
  localparam logic [9:0] TOK_MACK  = 10'h103;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        busy, done, ack_err, scl;
  wire         sda;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_eeprom_master #(
    .CLK_FREQ(CLK_FREQ),
    .SCL_FREQ(SCL_FREQ),
    .DEV_ADDR(DEV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model and bus monitor ----------------
  typedef enum {SL_IDLE, SL_RX, SL_ACK, SL_TX, SL_MACK} sl_t;
  logic       slave_low = 1'b0;
  bit         present = 1'b1;
  bit         sb_on = 1'b0;
  sl_t        sl = SL_IDLE;
  int         bitn = 0;
  int         byten = 0;
  logic [7:0] sh = '0;
  logic [7:0] tx = '0;
  logic [12:0] ptr = '0;
  logic       rd = 1'b0;
  logic [7:0] mem [0:8191];
  logic [9:0] exp_q [$];

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  task automatic observe(input logic [9:0] tok);
    if (sb_on) begin
      if (exp_q.size() == 0) check("bus_extra", 32'(tok), 32'h3ff);
      else                   check("bus_tok", 32'(tok), 32'(exp_q.pop_front()));
    end
  endtask

  always @(negedge sda) begin
    if (scl === 1'b1) begin
      sl = SL_RX;
      bitn = 0;
      byten = 0;
      observe(TOK_S);
    end
  end

  always @(posedge sda) begin
    if (scl === 1'b1) begin
      sl = SL_IDLE;
      observe(TOK_P);
    end
  end

  always @(posedge scl) begin
    case (sl)
      SL_RX: begin
        sh = {sh[6:0], (sda !== 1'b0)};
        bitn++;
      end
      SL_TX:   bitn++;
      SL_MACK: observe((sda === 1'b0) ? TOK_MACK : TOK_MNACK);
      default: ;
    endcase
  end

  always @(negedge scl) begin
    case (sl)
      SL_RX: begin
        if (bitn == 8) begin
          observe({2'b00, sh});
          if (byten == 0)                rd = sh[0];
          else if (byten == 1)           ptr[12:8] = sh[4:0];
          else if (byten == 2)           ptr[7:0] = sh;
          else if (byten == 3 && present) mem[ptr] = sh;
          byten++;
          slave_low = present;
          sl = SL_ACK;
        end
      end
      SL_ACK: begin
        slave_low = 1'b0;
        bitn = 0;
        if (rd && byten == 1) begin
          tx = mem[ptr];
          slave_low = present & !tx[7];
          sl = SL_TX;
        end else begin
          sl = SL_RX;
        end
      end
      SL_TX: begin
        if (bitn == 8) begin
          slave_low = 1'b0;
          sl = SL_MACK;
          ptr++;
        end else begin
          slave_low = present & !tx[3'(7 - bitn)];
        end
      end
      SL_MACK: sl = SL_IDLE;
      default: ;
    endcase
  end

  // SCL high-to-high spacing measured in clk cycles
  int   cyc_cnt = 0;
  int   last_period = 0;
  logic scl_prev = 1'b1;
  always @(negedge clk) begin
    cyc_cnt++;
    if (scl === 1'b1 && scl_prev === 1'b0) begin
      last_period = cyc_cnt;
      cyc_cnt = 0;
    end
    scl_prev = scl;
  end

  // ---------------- transaction driver ----------------
  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } res_t;
  res_t res_q [$];

  task automatic run_txn(input logic rw_i, input logic [12:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic abort, input logic exp_err,
                         input int poke_at);
    res_t r;
    bit   seen = 1'b0;
    exp_q.push_back(TOK_S);
    exp_q.push_back({2'b00, 4'b1010, DEV, 1'b0});
    if (abort) begin
      exp_q.push_back(TOK_P);
    end else begin
      exp_q.push_back({2'b00, 3'b000, a[12:8]});
      exp_q.push_back({2'b00, a[7:0]});
      if (!rw_i) begin
        exp_q.push_back({2'b00, d});
      end else begin
        exp_q.push_back(TOK_S);
        exp_q.push_back({2'b00, 4'b1010, DEV, 1'b1});
        exp_q.push_back(TOK_MNACK);
      end
      exp_q.push_back(TOK_P);
    end
    res_q.push_back('{rdata: exp_rd, err: exp_err});

    @(negedge clk);
    start = 1'b1; rw = rw_i; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
    rw = 1'($urandom); addr = 13'($urandom); wdata = 8'($urandom);
    check("busy_set", 32'(busy), 32'd1);
    for (int i = 1; i < 20000; i++) begin
      @(negedge clk);
      start = (poke_at > 0 && i == poke_at);
      if (start) begin
        rw = ~rw_i; addr = 13'h1AA;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (seen) begin
      r = res_q.pop_front();
      check("rdata", 32'(rdata), 32'(r.rdata));
      check("ack_err", 32'(ack_err), 32'(r.err));
      check("busy_clr", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_1clk", 32'(done), 32'd0);
    end else begin
      res_q.delete();
    end
    check("bus_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit nack_abort;
`ifdef ACK_CHECK_EN
    nack_abort = 1'b1;
`else
    nack_abort = 1'b0;
`endif
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda === 1'b1), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    sb_on = 1'b1;

    run_txn(1'b0, 13'h0123, 8'hA5, 8'h00, 1'b0, 1'b0, 0);
    check("mem_0123", 32'(mem[13'h0123]), 32'hA5);
    check("scl_period", 32'(last_period), 32'(4 * Q));

    run_txn(1'b1, 13'h0123, 8'h00, 8'hA5, 1'b0, 1'b0, 0);

    run_txn(1'b0, 13'h1FFF, 8'h3C, 8'hA5, 1'b0, 1'b0, 0);
    check("mem_1fff", 32'(mem[13'h1FFF]), 32'h3C);
    run_txn(1'b1, 13'h1FFF, 8'h00, 8'h3C, 1'b0, 1'b0, 0);

    run_txn(1'b0, 13'h0055, 8'h77, 8'h3C, 1'b0, 1'b0, 100);
    run_txn(1'b1, 13'h0055, 8'h00, 8'h77, 1'b0, 1'b0, 300);

    present = 1'b0;
    run_txn(1'b0, 13'h0010, 8'h99, 8'h77, nack_abort, nack_abort, 0);
    present = 1'b1;
    run_txn(1'b1, 13'h1FFF, 8'h00, 8'h3C, 1'b0, 1'b0, 0);

    // reset in the middle of the address-high byte
    sb_on = 1'b0;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 13'h0ABC; wdata = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    repeat (44 * Q) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda", 32'(sda === 1'b1), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * Q) @(negedge clk);
    exp_q.delete();
    sb_on = 1'b1;

    run_txn(1'b0, 13'h00AB, 8'h5A, 8'h00, 1'b0, 1'b0, 0);
    check("mem_00ab", 32'(mem[13'h00AB]), 32'h5A);
    run_txn(1'b1, 13'h00AB, 8'h00, 8'h5A, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
